// File: rtl/seq_signed_layer_mul.sv
// -----------------------------------------------------------------------------
// seq_signed_layer_mul
//
// Sequential signed multiplier. It consumes the multiplier two bits per clock
// ("layers"). Each layer term a*digit is shifted left by 2k and added into an
// accumulator. The lower slices use digits 0..3. The top slice uses the
// two's-complement digit set {0, 1, -2, -1}, so a signed b needs no correction
// step. Latency is fixed at WIDTH_B/2 cycles from accept to out_valid.
//
// Parameters:
//   WIDTH_A   signed multiplicand width (>= 4)
//   WIDTH_B   signed multiplier width (even, >= 4)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid (sampled only in IDLE)
//   in_ready   high in IDLE
//   a, b       signed operands
//   out_valid  high in DONE; product is valid
//   out_ready  consumer accepts product (sampled only in DONE)
//   product    signed result, WIDTH_A+WIDTH_B bits; holds last result
//   busy       high in RUN
//
// Configuration macro:
//   APPROX_LAYER_EN  when defined, bit 0 of every layer term is cleared before
//                    shifting and accumulation (approximate product). Latency
//                    and handshake are unchanged.
// -----------------------------------------------------------------------------
module seq_signed_layer_mul #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       busy
);

    localparam int WIDTH_P = WIDTH_A + WIDTH_B;
    localparam int WIDTH_T = WIDTH_A + 2;       // layer term width: a * [-2..3]
    localparam int N_SLICE = WIDTH_B / 2;
    localparam int KW      = $clog2(N_SLICE);   // N_SLICE >= 2, so KW >= 1
    localparam logic [KW-1:0] K_LAST = KW'(N_SLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_A-1:0]   a_q, a_d;
    logic [WIDTH_B-1:0]   b_q, b_d;        // shifted right 2 bits per layer
    logic [WIDTH_P-1:0]   acc_q, acc_d;
    logic [KW-1:0]        k_q, k_d;
    logic [WIDTH_P-1:0]   product_q, product_d;

    logic [WIDTH_T-1:0]   a_x;
    logic [WIDTH_T-1:0]   a_x2;
    logic [1:0]           slice;
    logic [WIDTH_T-1:0]   term;
    logic [WIDTH_P-1:0]   term_p;
    logic [WIDTH_P-1:0]   acc_sum;

    // -------------------------------------------------------------------------
    // Layer term for the current slice. The slice is always b_q[1:0] because
    // b_q shifts down as layers are consumed.
    // -------------------------------------------------------------------------
    always_comb begin
        a_x   = {{2{a_q[WIDTH_A-1]}}, a_q};
        a_x2  = {a_x[WIDTH_T-2:0], 1'b0};
        slice = b_q[1:0];
        term  = '0;
        if (k_q == K_LAST) begin
            // The top slice carries the negative MSB weight: digit = b_low - 2*b_high.
            case (slice)
                2'b01:   term = a_x;
                2'b10:   term = -a_x2;
                2'b11:   term = -a_x;
                default: term = '0;
            endcase
        end else begin
            case (slice)
                2'b01:   term = a_x;
                2'b10:   term = a_x2;
                2'b11:   term = a_x + a_x2;
                default: term = '0;
            endcase
        end
`ifdef APPROX_LAYER_EN
        term[0] = 1'b0;
`endif
        term_p  = {{(WIDTH_P-WIDTH_T){term[WIDTH_T-1]}}, term};
        acc_sum = acc_q + (term_p << {k_q, 1'b0});
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        k_d       = k_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                b_d   = b_q >> 2;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Retire only. The earliest new accept is the next edge, which sees IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_signed_layer_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_layer_mul
//
// Self-checking bench for seq_signed_layer_mul (8x8). Expected products come
// from an arithmetic reference model: the plain signed product, or the
// digit-by-digit sum with bit 0 cleared when APPROX_LAYER_EN is defined.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_signed_layer_mul;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int WP = WA + WB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [WP-1:0] product;
    logic          busy;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [WP-1:0] last_result = '0;

    always #5 clk = ~clk;

    seq_signed_layer_mul #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model computed from the layer definition with integer arithmetic.
    function automatic logic [WP-1:0] model(input logic [WA-1:0] ma, input logic [WB-1:0] mb);
        longint sa;
        longint sb;
        longint acc;
        longint t;
        int     d;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
`ifdef APPROX_LAYER_EN
        acc = 0;
        for (int k = 0; k < WB/2; k++) begin
            if (k == WB/2 - 1) d = int'(mb[2*k]) - 2 * int'(mb[2*k+1]);
            else               d = int'(mb[2*k]) + 2 * int'(mb[2*k+1]);
            t   = sa * longint'(d);
            t   = t & ~longint'(1);
            acc = acc + t * (longint'(1) << (2*k));
        end
        sb = 0;
        return WP'(acc + sb);
`else
        acc = sa * sb;
        return WP'(acc);
`endif
    endfunction

    // One complete transaction. Starts and ends on a falling edge. Checks the
    // fixed latency, RUN status, held product, and hold-in-DONE behavior.
    task automatic run_op(input logic [WA-1:0] op_a, input logic [WB-1:0] op_b,
                          input logic [WP-1:0] exp, input int hold, input string tag);
        @(negedge clk);
        check({tag, " idle"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        for (int i = 0; i < WB/2; i++) begin
            @(negedge clk);
            // During RUN, in_valid, operand changes, and out_ready must have no effect.
            in_valid  = 1'($urandom_range(0, 1));
            a         = WA'($urandom);
            b         = WB'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            check({tag, " run_status"}, {29'd0, in_ready, out_valid, busy}, 32'b001);
            check({tag, " run_product"}, 32'(product), 32'(last_result));
        end
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " done_status"}, {29'd0, in_ready, out_valid, busy}, 32'b010);
        check({tag, " product"}, 32'(product), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = WA'($urandom);
            b        = WB'($urandom);
            @(negedge clk);
            check({tag, " hold_status"}, {29'd0, in_ready, out_valid, busy}, 32'b010);
            check({tag, " hold_product"}, 32'(product), 32'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " retire_status"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
        check({tag, " retire_product"}, 32'(product), 32'(exp));
        last_result = exp;
    endtask

    initial begin
        logic [WP-1:0] exp_q[$];
        logic [WA-1:0] ra;
        logic [WB-1:0] rb;
        logic [WP-1:0] e;
        int            got;
        int            last_cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        check("reset_status", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
`ifdef APPROX_LAYER_EN
        run_op(8'd1, 8'd1, 16'd0, 0, "approx_1x1");
        run_op(8'd3, 8'd1, 16'd2, 0, "approx_3x1");
        run_op(8'd5, 8'd6, model(8'd5, 8'd6), 10, "backpressure");
        run_op(8'h80, 8'h80, model(8'h80, 8'h80), 0, "m128xm128");
`else
        run_op(8'd7, 8'hFD, 16'hFFEB, 0, "p7xm3");
        run_op(8'h80, 8'h80, 16'h4000, 1, "m128xm128");
        run_op(8'h7F, 8'h80, 16'hC080, 0, "p127xm128");
        run_op(8'd5, 8'd6, 16'd30, 10, "backpressure");
`endif
        run_op(8'd0, 8'h9B, model(8'd0, 8'h9B), 0, "a_zero");
        run_op(8'hC4, 8'd0, model(8'hC4, 8'd0), 0, "b_zero");
        run_op(8'h7F, 8'h7F, model(8'h7F, 8'h7F), 0, "p127xp127");
        run_op(8'hFF, 8'hFF, model(8'hFF, 8'hFF), 0, "m1xm1");

        // Random vectors
        for (int n = 0; n < 20; n++) begin
            ra = WA'($urandom);
            rb = WB'($urandom);
            run_op(ra, rb, model(ra, rb), int'($urandom_range(0, 3)), "random");
        end

        // Reset two cycles after accepting 3*3: the operation is discarded.
        @(negedge clk);
        a        = 8'd3;
        b        = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_status", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("midrun_reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_status", {29'd0, in_ready, out_valid, busy}, 32'b100);
            check("post_reset_product", 32'(product), 32'd0);
        end
        last_result = '0;

        // Back-to-back stream: out_ready tied high; in_valid high until the
        // fourth pair is accepted, with junk operands while busy.
        got      = 0;
        last_cyc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                check("b2b_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_product", 32'(product), 32'(e));
                    last_result = e;
                end
                if (last_cyc >= 0) check("b2b_interval", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                got++;
            end
            if (in_ready && got + exp_q.size() < 4) begin
                ra = WA'($urandom);
                rb = WB'($urandom);
                a  = ra;
                b  = rb;
                in_valid = 1'b1;
                exp_q.push_back(model(ra, rb));
            end else begin
                a        = WA'($urandom);
                b        = WB'($urandom);
                in_valid = (got + exp_q.size() < 4);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 32'(got), 32'd4);
        check("b2b_final_status", {29'd0, in_ready, out_valid, busy}, 32'b100);

        // A final exact transaction after the stream checks that the product is retained.
        run_op(8'hA5, 8'h5A, model(8'hA5, 8'h5A), 2, "after_stream");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
